// File: rtl/mux_2bit_2to1_pkg.sv
// Shared constants and the default data word type for the 2:1 steering mux.
package mux2_pkg;

    localparam int DATA_W_DEF = 2;
    localparam int CNT_W_DEF  = 8;

    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/mux_2bit_2to1_if.sv
// Bus bundle for the 2:1 mux: two sources, select, and the mux/status outputs.
// The parity signal exists only when MUX2_PARITY_EN is defined.
interface mux_2bit_2to1_if
    import mux2_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_q;
    logic             s_q;
    logic             sel_chg;
    logic [CNT_W-1:0] tog_cnt;
`ifdef MUX2_PARITY_EN
    logic             parity;
`endif

    modport master (
        output a, b, s,
`ifdef MUX2_PARITY_EN
        input  parity,
`endif
        input  z, z_q, s_q, sel_chg, tog_cnt
    );

    modport slave (
        input  a, b, s,
`ifdef MUX2_PARITY_EN
        output parity,
`endif
        output z, z_q, s_q, sel_chg, tog_cnt
    );

endinterface

// File: rtl/mux_2bit_2to1_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mux_2bit_2to1.sv
// 2:1 mux with a combinational output plus registered copy and select-activity status.
// Optional registered parity of z_q is enabled by defining MUX2_PARITY_EN.
module mux_2bit_2to1
    import mux2_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mux_2bit_2to1_if.slave  bus
);

    logic [WIDTH-1:0] z_q_r;
    logic             s_q_r;
    logic             sel_chg_r;
    logic             s_changed;

    assign bus.z     = bus.s ? bus.b : bus.a;
    assign s_changed = (bus.s != s_q_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q_r     <= '0;
            s_q_r     <= 1'b0;
            sel_chg_r <= 1'b0;
        end else begin
            z_q_r     <= bus.z;
            s_q_r     <= bus.s;
            sel_chg_r <= s_changed;
        end
    end

    assign bus.z_q     = z_q_r;
    assign bus.s_q     = s_q_r;
    assign bus.sel_chg = sel_chg_r;

    sat_counter #(
        .W (CNT_W)
    ) u_tog_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (s_changed),
        .count (bus.tog_cnt)
    );

`ifdef MUX2_PARITY_EN
    // Parity is taken from z so it lands in the same cycle as z_q.
    logic parity_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= ^bus.z;
        end
    end

    assign bus.parity = parity_r;
`endif

endmodule

// File: tb/tb_mux_2bit_2to1.sv
// Self-checking bench: directed steps plus random traffic against a sample-based reference model.
// Runs a default-width DUT and a CNT_W=2 DUT side by side on identical inputs.
module tb_mux_2bit_2to1;
    import mux2_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_2bit_2to1_if #(.WIDTH(2), .CNT_W(8)) bus_d ();
    mux_2bit_2to1_if #(.WIDTH(2), .CNT_W(2)) bus_s ();

    mux_2bit_2to1 #(.WIDTH(2), .CNT_W(8)) dut_default (
        .clk (clk),
        .rst (rst),
        .bus (bus_d.slave)
    );

    mux_2bit_2to1 #(.WIDTH(2), .CNT_W(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: values captured at each sampling edge, plus a raw change tally.
    data_t m_zq;
    logic  m_sq;
    logic  m_chg;
    int    m_changes;
    data_t cur_a;
    data_t cur_b;
    logic  cur_s;

    function automatic data_t pick(input data_t a, input data_t b, input logic s);
        data_t src [2];
        src[0] = a;
        src[1] = b;
        return src[int'(s)];
    endfunction

    function automatic int satMin(input int n, input int bits);
        int top;
        top = (1 << bits) - 1;
        return (n > top) ? top : n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input data_t a, input data_t b, input logic s);
        cur_a   = a;
        cur_b   = b;
        cur_s   = s;
        bus_d.a = a;
        bus_d.b = b;
        bus_d.s = s;
        bus_s.a = a;
        bus_s.b = b;
        bus_s.s = s;
        #1;
        checkOutput("z_comb", 32'(bus_d.z), 32'(pick(a, b, s)));
    endtask

    task automatic modelReset();
        m_zq      = '0;
        m_sq      = 1'b0;
        m_chg     = 1'b0;
        m_changes = 0;
    endtask

    task automatic checkRegistered(input string tag);
        checkOutput({tag, "_z_q"},     32'(bus_d.z_q),     32'(m_zq));
        checkOutput({tag, "_s_q"},     32'(bus_d.s_q),     32'(m_sq));
        checkOutput({tag, "_sel_chg"}, 32'(bus_d.sel_chg), 32'(m_chg));
        checkOutput({tag, "_tog_cnt"}, 32'(bus_d.tog_cnt), 32'(satMin(m_changes, 8)));
        checkOutput({tag, "_tog_cnt2"}, 32'(bus_s.tog_cnt), 32'(satMin(m_changes, 2)));
`ifdef MUX2_PARITY_EN
        checkOutput({tag, "_parity"},  32'(bus_d.parity),  32'(^m_zq));
`endif
    endtask

    // One clock: model samples the current inputs, then outputs are checked mid-low-phase.
    task automatic tick(input string tag);
        m_chg = (cur_s != m_sq);
        if (m_chg) m_changes++;
        m_zq = pick(cur_a, cur_b, cur_s);
        m_sq = cur_s;
        @(posedge clk);
        @(negedge clk);
        checkRegistered(tag);
    endtask

    initial begin
        data_t sweep;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        modelReset();
        applyStimulus(2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        checkRegistered("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // s=0 sweep: z follows a, b is ignored
        for (int i = 0; i < 4; i++) begin
            sweep = data_t'(i);
            applyStimulus(sweep, 2'b00, 1'b0);
            tick("sweep_a");
        end
        applyStimulus(2'b11, 2'b11, 1'b0);
        checkOutput("b_ignored", 32'(bus_d.z), 32'(2'b11));

        // s=1 sweep: z follows b, a is ignored
        for (int i = 0; i < 4; i++) begin
            sweep = data_t'(i);
            applyStimulus(2'b01, sweep, 1'b1);
            tick("sweep_b");
        end
        applyStimulus(2'b10, 2'b11, 1'b1);
        checkOutput("a_ignored", 32'(bus_d.z), 32'(2'b11));
        tick("pre_toggle");

        // Four more select changes bring the count to 5 with z_q = 11
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b11, ~cur_s);
            tick("build_cnt");
        end
        checkOutput("pre_rst_cnt", 32'(bus_d.tog_cnt), 32'd5);
        checkOutput("pre_rst_zq",  32'(bus_d.z_q),     32'(2'b11));

        // Mid-cycle asynchronous reset, then z must still track its inputs
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkRegistered("async_rst");
        applyStimulus(2'b10, 2'b01, 1'b0);
        checkOutput("z_in_reset", 32'(bus_d.z), 32'(2'b10));
        @(posedge clk);
        @(negedge clk);
        checkRegistered("held_rst");
        rst = 1'b0;

        // Toggle s every 3 clocks, 4 times
        applyStimulus(2'b01, 2'b10, 1'b0);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(cur_a, cur_b, ~cur_s);
            for (int c = 0; c < 3; c++) tick("toggle3");
        end
        checkOutput("toggle_cnt4", 32'(bus_d.tog_cnt), 32'd4);
        checkOutput("small_sat3",  32'(bus_s.tog_cnt), 32'd3);
        for (int t = 0; t < 2; t++) begin
            applyStimulus(cur_a, cur_b, ~cur_s);
            tick("toggle_more");
        end
        checkOutput("small_nowrap", 32'(bus_s.tog_cnt), 32'd3);

`ifdef MUX2_PARITY_EN
        applyStimulus(2'b01, 2'b00, 1'b0);
        tick("par_a01");
        checkOutput("parity_01", 32'(bus_d.parity), 32'd1);
        applyStimulus(2'b11, 2'b00, 1'b0);
        tick("par_a11");
        checkOutput("parity_11", 32'(bus_d.parity), 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            applyStimulus(data_t'($urandom_range(3, 0)), data_t'($urandom_range(3, 0)),
                          1'($urandom_range(1, 0)));
            tick("random");
        end

        // Force the 8-bit counter into saturation
        for (int i = 0; i < 270; i++) begin
            applyStimulus(data_t'($urandom_range(3, 0)), data_t'($urandom_range(3, 0)), ~cur_s);
            tick("saturate");
        end
        checkOutput("sat_255", 32'(bus_d.tog_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2bit_2to1.md
Name: mux_2bit_2to1

Overview:
- Parameterised 2:1 multiplexer; default data width is 2 bits.
- Provides a combinational output z = s ? b : a for downstream glue logic.
- Also provides a registered copy of that output and select-activity status for synchronous consumers and debug.
- Sits in datapath steering between two equal-width sources.

Parameters:
- WIDTH, 2, data width of a, b, z, z_q.
- CNT_W, 8, width of the saturating select-toggle counter.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a  input  WIDTH  data source selected when s=0.
- b  input  WIDTH  data source selected when s=1.
- s  input  1  select.
- z  output  WIDTH  combinational mux result.
- z_q  output  WIDTH  registered mux result.
- s_q  output  1  registered select.
- sel_chg  output  1  one-cycle pulse when the sampled select differs from the previous sample.
- tog_cnt  output  CNT_W  saturating count of select changes since reset.
- parity  output  1  only present when MUX2_PARITY_EN is defined; see Optional Feature.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named clk and rst.
- z = (s == 1) ? b : a.
  - Purely combinational, zero latency, no dependence on clk or rst.
  - Valid during reset.
- If s is X/Z, z follows the simulator's ?: semantics; no special handling.
- Reset (rst=1, asserted at any time, including mid-operation) immediately forces z_q=0, s_q=0, sel_chg=0, tog_cnt=0. Release is synchronous to the next clk edge.
- Every rising clk edge with rst=0:
  - z_q <= z.
  - s_q <= s.
  - sel_chg <= (s != s_q).
  - tog_cnt <= tog_cnt+1 if s != s_q and tog_cnt != all-ones; otherwise it holds.
- Latency: z_q, s_q and sel_chg each lag the inputs by exactly 1 cycle.
- Counter boundary: tog_cnt saturates at 2^CNT_W-1 (255 by default) and never wraps.
- After reset, s_q=0, so a first sampled s=1 counts as a change.
- If a, b and s change in the same cycle, z_q captures the new combinational z. There is no ordering hazard because the design has a single sampling point.
- Input changes between clock edges are not visible on the registered outputs; only the value at the edge is captured.
- No handshake, no state machine beyond the registers above.

Optional Feature:
- Macro: MUX2_PARITY_EN.
- Defined:
  - Adds output parity = XOR-reduction of z_q, registered with it (same 1-cycle latency).
  - parity resets to 0.
- Not defined:
  - The parity port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package mux2_pkg holds the default constants DATA_W_DEF=2 and CNT_W_DEF=8, plus a typedef for the data word.
- One natural sub-module, sat_counter: a CNT_W-bit saturating incrementer with async active-high reset and increment enable. The top instantiates it for tog_cnt.
- The mux itself stays in the top.

Test Plan:
- Reset: assert rst mid-operation with tog_cnt=5 and z_q=2'b11 -> z_q, s_q, sel_chg and tog_cnt are all 0 immediately, without waiting for clk; z still tracks its inputs.
- s=0, b=2'b00, sweep a=00,01,10,11 -> z equals a immediately each step; z_q equals a one clock later; changing b to 11 leaves z unchanged.
- s=1, a=2'b01, sweep b=00,01,10,11 -> z equals b immediately; changing a to 10 has no effect on z.
- Toggle s every 3 clocks, 4 times, after reset -> sel_chg pulses high for exactly 1 cycle after each change; tog_cnt ends at 4.
- With CNT_W=2, toggle s 6 times -> tog_cnt reaches 3 and stays at 3 (no wrap).
- MUX2_PARITY_EN defined, s=0, a=2'b01 -> parity=1 one cycle later; a=2'b11 -> parity=0.
